// File: rtl/washer_defs.sv
// Shared phase indices and timer state encoding for the wash controller.
package washer_defs;

    localparam int PH_FILL  = 0;
    localparam int PH_WASH  = 1;
    localparam int PH_RINSE = 2;
    localparam int PH_SPIN  = 3;
    localparam int PH_DRY   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/washer_dur_regs.sv
// Per-phase duration register file, reset to the packed default durations.
// Latency: write lands at the clock edge; read port is combinational (old value on a same-edge write).
// Backpressure: none; writes to phase indices past the last phase are dropped.
module washer_dur_regs #(
    parameter int NUM_PH = 5,
    parameter int CNT_W  = 8,
    parameter logic [NUM_PH*CNT_W-1:0] DEFAULT_DUR = {8'd25, 8'd8, 8'd15, 8'd20, 8'd10},
    parameter int PH_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PH_W-1:0]  wr_ph,
    input  logic [CNT_W-1:0] wr_dur,
    input  logic [PH_W-1:0]  rd_ph,
    output logic [CNT_W-1:0] rd_dur
);

    localparam logic [PH_W:0] NUM_PH_V = (PH_W+1)'(NUM_PH);

    logic [CNT_W-1:0] dur [NUM_PH];
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = we && ({1'b0, wr_ph} < NUM_PH_V);
    assign rd_ok = {1'b0, rd_ph} < NUM_PH_V;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PH; i++) begin
                dur[i] <= DEFAULT_DUR[i*CNT_W +: CNT_W];
            end
        end else if (wr_ok) begin
            dur[wr_ph] <= wr_dur;
        end
    end

    assign rd_dur = rd_ok ? dur[rd_ph] : '0;

endmodule

// File: rtl/washer_phase_timer.sv
// Phase-duration countdown timer with hold, abort, sticky done flags and expiry pulse.
// Latency: done/expire appear D edges after start (same edge when D==0); each held edge adds one.
// Backpressure: none; hold freezes the count, abort and restart take effect on any edge.
module washer_phase_timer
    import washer_defs::*;
#(
    parameter int NUM_PH = 5,
    parameter int CNT_W  = 8,
    parameter logic [NUM_PH*CNT_W-1:0] DEFAULT_DUR = {8'd25, 8'd8, 8'd15, 8'd20, 8'd10},
    localparam int PH_W  = $clog2(NUM_PH)
) (
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic [PH_W-1:0]   sel,
    input  logic              hold,
    input  logic              abort,
    input  logic              cfg_we,
    input  logic [PH_W-1:0]   cfg_ph,
    input  logic [CNT_W-1:0]  cfg_dur,
    output logic [NUM_PH-1:0] done,
    output logic              expire,
    output logic              busy,
    output logic              paused,
    output logic [CNT_W-1:0]  remaining,
    output logic [PH_W-1:0]   cur_ph
);

    localparam logic [PH_W:0]    NUM_PH_V = (PH_W+1)'(NUM_PH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  rem_n;
    logic [PH_W-1:0]   ph_n;
    logic [NUM_PH-1:0] done_n;
    logic              expire_n;
    logic [CNT_W-1:0]  sel_dur;
    logic              start_ok;

    washer_dur_regs #(
        .NUM_PH      (NUM_PH),
        .CNT_W       (CNT_W),
        .DEFAULT_DUR (DEFAULT_DUR),
        .PH_W        (PH_W)
    ) u_dur_regs (
        .clk    (clk),
        .rst    (R),
        .we     (cfg_we),
        .wr_ph  (cfg_ph),
        .wr_dur (cfg_dur),
        .rd_ph  (sel),
        .rd_dur (sel_dur)
    );

    assign start_ok = start && ({1'b0, sel} < NUM_PH_V);

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state     <= ST_IDLE;
            remaining <= '0;
            cur_ph    <= '0;
            done      <= '0;
            expire    <= 1'b0;
            busy      <= 1'b0;
            paused    <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= rem_n;
            cur_ph    <= ph_n;
            done      <= done_n;
            expire    <= expire_n;
            busy      <= (state_n == ST_RUN) || (state_n == ST_PAUSE);
            paused    <= (state_n == ST_PAUSE);
        end
    end

    always_comb begin
        state_n  = state;
        rem_n    = remaining;
        ph_n     = cur_ph;
        done_n   = done;
        expire_n = 1'b0;

        if (abort) begin
            state_n = ST_IDLE;
            rem_n   = '0;
        end else if (start_ok) begin
            // Restart from any state; a zero duration completes on the start edge itself.
            ph_n   = sel;
            done_n = '0;
            if (sel_dur == '0) begin
                state_n      = ST_DONE;
                rem_n        = '0;
                done_n[sel]  = 1'b1;
                expire_n     = 1'b1;
            end else begin
                state_n = ST_RUN;
                rem_n   = sel_dur;
            end
        end else if ((state == ST_RUN) || (state == ST_PAUSE)) begin
            if (hold) begin
                state_n = ST_PAUSE;
            end else if (remaining <= ONE) begin
                state_n        = ST_DONE;
                rem_n          = '0;
                done_n[cur_ph] = 1'b1;
                expire_n       = 1'b1;
            end else begin
                state_n = ST_RUN;
                rem_n   = remaining - ONE;
            end
        end
    end

endmodule

// File: tb/tb_washer_phase_timer.sv
// Directed bench for washer_phase_timer: vector table plus multi-cycle sequences.
module tb_washer_phase_timer;

    logic       clk = 1'b0;
    logic       R;
    logic       start;
    logic [2:0] sel;
    logic       hold;
    logic       abort;
    logic       cfg_we;
    logic [2:0] cfg_ph;
    logic [7:0] cfg_dur;
    logic [4:0] done;
    logic       expire;
    logic       busy;
    logic       paused;
    logic [7:0] remaining;
    logic [2:0] cur_ph;

    int checks = 0;
    int errors = 0;

    washer_phase_timer dut (
        .clk       (clk),
        .R         (R),
        .start     (start),
        .sel       (sel),
        .hold      (hold),
        .abort     (abort),
        .cfg_we    (cfg_we),
        .cfg_ph    (cfg_ph),
        .cfg_dur   (cfg_dur),
        .done      (done),
        .expire    (expire),
        .busy      (busy),
        .paused    (paused),
        .remaining (remaining),
        .cur_ph    (cur_ph)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [2:0] sl;
        logic       hd;
        logic       ab;
        logic       we;
        logic [2:0] cp;
        logic [7:0] cd;
        logic [4:0] e_done;
        logic       e_exp;
        logic       e_busy;
        logic       e_paused;
        logic [7:0] e_rem;
        logic [2:0] e_ph;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        start = 1'b0; sel = 3'd0; hold = 1'b0; abort = 1'b0;
        cfg_we = 1'b0; cfg_ph = 3'd0; cfg_dur = 8'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        R = 1'b0;
    endtask

    task automatic add(input logic st, input logic [2:0] sl, input logic hd, input logic ab,
                       input logic we, input logic [2:0] cp, input logic [7:0] cd,
                       input logic [4:0] e_done, input logic e_exp, input logic e_busy,
                       input logic e_paused, input logic [7:0] e_rem, input logic [2:0] e_ph);
        vec_t v;
        v.st = st; v.sl = sl; v.hd = hd; v.ab = ab; v.we = we; v.cp = cp; v.cd = cd;
        v.e_done = e_done; v.e_exp = e_exp; v.e_busy = e_busy; v.e_paused = e_paused;
        v.e_rem = e_rem; v.e_ph = e_ph;
        tbl.push_back(v);
    endtask

    initial begin
        int exp_edge;
        int pulses;

        R = 1'b1;
        idle_in();
        #3;
        chk("reset_done",   32'(done),      32'd0);
        chk("reset_expire", 32'(expire),    32'd0);
        chk("reset_busy",   32'(busy),      32'd0);
        chk("reset_paused", 32'(paused),    32'd0);
        chk("reset_rem",    32'(remaining), 32'd0);
        chk("reset_ph",     32'(cur_ph),    32'd0);
        do_reset();

        //   st sl   hd ab we cp   cd      done      exp busy pau rem     ph
        add(1, 3'd0, 0, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 0, 8'd10, 3'd0);
        add(0, 3'd0, 0, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 0, 8'd9,  3'd0);
        add(0, 3'd0, 1, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 1, 8'd9,  3'd0);
        add(0, 3'd0, 1, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 1, 8'd9,  3'd0);
        add(0, 3'd0, 0, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 0, 8'd8,  3'd0);
        add(0, 3'd0, 0, 1, 0, 3'd0, 8'd0, 5'b00000, 0, 0, 0, 8'd0,  3'd0);
        add(1, 3'd5, 0, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 0, 0, 8'd0,  3'd0);
        add(0, 3'd0, 0, 0, 1, 3'd6, 8'd0, 5'b00000, 0, 0, 0, 8'd0,  3'd0);
        add(0, 3'd0, 0, 0, 1, 3'd3, 8'd0, 5'b00000, 0, 0, 0, 8'd0,  3'd0);
        add(1, 3'd3, 0, 0, 0, 3'd0, 8'd0, 5'b01000, 1, 0, 0, 8'd0,  3'd3);
        add(0, 3'd0, 0, 0, 0, 3'd0, 8'd0, 5'b01000, 0, 0, 0, 8'd0,  3'd3);
        add(1, 3'd3, 0, 0, 1, 3'd3, 8'd2, 5'b01000, 1, 0, 0, 8'd0,  3'd3);
        add(1, 3'd3, 0, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 0, 8'd2,  3'd3);
        add(0, 3'd0, 0, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 0, 8'd1,  3'd3);
        add(0, 3'd0, 0, 0, 0, 3'd0, 8'd0, 5'b01000, 1, 0, 0, 8'd0,  3'd3);
        add(0, 3'd0, 0, 0, 0, 3'd0, 8'd0, 5'b01000, 0, 0, 0, 8'd0,  3'd3);
        add(1, 3'd1, 1, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 0, 8'd20, 3'd1);
        add(1, 3'd2, 0, 1, 0, 3'd0, 8'd0, 5'b00000, 0, 0, 0, 8'd0,  3'd1);
        add(1, 3'd2, 0, 0, 0, 3'd0, 8'd0, 5'b00000, 0, 1, 0, 8'd15, 3'd2);
        add(0, 3'd0, 0, 1, 0, 3'd0, 8'd0, 5'b00000, 0, 0, 0, 8'd0,  3'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; sel = tbl[i].sl; hold = tbl[i].hd; abort = tbl[i].ab;
            cfg_we = tbl[i].we; cfg_ph = tbl[i].cp; cfg_dur = tbl[i].cd;
            tick();
            chk($sformatf("vec%0d {done,exp,busy,paused,rem,ph}", i),
                32'({done, expire, busy, paused, remaining, cur_ph}),
                32'({tbl[i].e_done, tbl[i].e_exp, tbl[i].e_busy, tbl[i].e_paused,
                     tbl[i].e_rem, tbl[i].e_ph}));
        end
        idle_in();

        // Fill, default duration 10: count 10..1, then expire pulse on edge 10.
        do_reset();
        start = 1'b1; sel = 3'd0;
        tick();
        idle_in();
        chk("fill_start_rem", 32'(remaining), 32'd10);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("fill_rem_e%0d", k), 32'({remaining, expire, busy}),
                32'({8'(10 - k), 1'b0, 1'b1}));
        end
        tick();
        chk("fill_done_edge10", 32'({done, expire, busy, remaining}),
            32'({5'b00001, 1'b1, 1'b0, 8'd0}));
        tick();
        chk("fill_after_pulse", 32'({done, expire, busy}), 32'({5'b00001, 1'b0, 1'b0}));

        // Wash, 20 cycles with hold sampled on edges 5..9: completion on edge 25.
        start = 1'b1; sel = 3'd1;
        tick();
        idle_in();
        exp_edge = -1;
        pulses   = 0;
        for (int e = 1; e <= 40; e++) begin
            hold = (e >= 5) && (e <= 9);
            tick();
            if (hold) chk($sformatf("wash_hold_e%0d", e), 32'({paused, busy, remaining}),
                          32'({1'b1, 1'b1, 8'd16}));
            if (expire) begin
                pulses++;
                if (exp_edge < 0) exp_edge = e;
            end
        end
        hold = 1'b0;
        chk("wash_expire_edge", 32'(exp_edge), 32'd25);
        chk("wash_pulse_count", 32'(pulses), 32'd1);
        chk("wash_done", 32'(done), 32'b00010);

        // Spin: rewrite its duration mid-run; the running count keeps the old value.
        do_reset();
        start = 1'b1; sel = 3'd3;
        tick();
        idle_in();
        tick();
        cfg_we = 1'b1; cfg_ph = 3'd3; cfg_dur = 8'd3;
        tick();
        idle_in();
        chk("spin_inflight_rem", 32'(remaining), 32'd6);
        for (int e = 3; e <= 7; e++) tick();
        chk("spin_not_early", 32'({expire, remaining}), 32'({1'b0, 8'd1}));
        tick();
        chk("spin_done_edge8", 32'({done, expire}), 32'({5'b01000, 1'b1}));
        start = 1'b1; sel = 3'd3;
        tick();
        idle_in();
        chk("spin_new_dur", 32'({remaining, done}), 32'({8'd3, 5'b00000}));

        // Rinse aborted at remaining 7, then dry restarted at remaining 12.
        start = 1'b1; sel = 3'd2;
        tick();
        idle_in();
        for (int k = 0; k < 8; k++) tick();
        chk("rinse_rem7", 32'(remaining), 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("rinse_abort", 32'({busy, expire, remaining, done}), 32'({1'b0, 1'b0, 8'd0, 5'b00000}));
        tick();
        chk("rinse_abort_quiet", 32'({busy, expire, remaining}), 32'({1'b0, 1'b0, 8'd0}));
        start = 1'b1; sel = 3'd4;
        tick();
        idle_in();
        for (int k = 0; k < 13; k++) tick();
        chk("dry_rem12", 32'(remaining), 32'd12);
        start = 1'b1; sel = 3'd4;
        tick();
        idle_in();
        chk("dry_restart", 32'({cur_ph, remaining, done, busy}),
            32'({3'd4, 8'd25, 5'b00000, 1'b1}));

        // Asynchronous reset mid-run restores outputs and the rewritten duration.
        cfg_we = 1'b1; cfg_ph = 3'd0; cfg_dur = 8'd4;
        tick();
        idle_in();
        start = 1'b1; sel = 3'd0;
        tick();
        idle_in();
        tick();
        chk("pre_reset_rem", 32'(remaining), 32'd3);
        #3;
        R = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({done, expire, busy, paused, remaining, cur_ph}), 32'd0);
        #1;
        R = 1'b0;
        start = 1'b1; sel = 3'd0;
        tick();
        idle_in();
        chk("reset_restores_dur", 32'(remaining), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
